// File: rtl/pcie_pkg.sv
// Shared symbol codes, deframer state encoding and FIFO entry layout.
// No logic; no latency or backpressure of its own.
package pcie_pkg;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] dat;
    } fifo_entry_t;

endpackage

// File: rtl/pcie_rx_commit_fifo.sv
// Commit/rollback FIFO: writes land at a speculative pointer, become readable only on commit.
// Commit visible at head one cycle after the edge; reader stalls by holding rd_en low.
module pcie_rx_commit_fifo
    import pcie_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  fifo_entry_t wr_dat,
    input  logic        commit,
    input  logic        rollback,
    input  logic        rd_en,
    output fifo_entry_t rd_dat,
    output logic        rd_vld,
    output logic        full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fifo_entry_t         mem_q [DEPTH];
    logic [PW-1:0]       wp_q, wp_d;
    logic [PW-1:0]       spec_wp_q, spec_wp_d;
    logic [PW-1:0]       rp_q, rp_d;

    assign rd_vld = (rp_q != wp_q);
    assign rd_dat = mem_q[rp_q[AW-1:0]];
    // Wrap bits differ with equal addresses: speculative writes have caught up with the reader.
    assign full   = (spec_wp_q[AW] != rp_q[AW]) && (spec_wp_q[AW-1:0] == rp_q[AW-1:0]);

    always_comb begin
        spec_wp_d = spec_wp_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        if (wr_en) begin
            spec_wp_d = spec_wp_q + PW'(1);
        end
        if (rollback) begin
            spec_wp_d = wp_q;
        end
        if (commit) begin
            wp_d = spec_wp_d;
        end
        if (rd_en && rd_vld) begin
            rp_d = rp_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q      <= '0;
            spec_wp_q <= '0;
            rp_q      <= '0;
        end else begin
            wp_q      <= wp_d;
            spec_wp_q <= spec_wp_d;
            rp_q      <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[spec_wp_q[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/pcie_rx_deframer.sv
// Strips STP/END framing from the PHY byte stream and releases only whole good packets to the DLL.
// First byte visible the cycle after END is taken; READY_IN low holds the head byte stable.
module pcie_rx_deframer
    import pcie_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 12
) (
    input  logic       CLK0,
    input  logic       RESET,
    input  logic [7:0] DATA_IN,
    input  logic       K_IN,
    input  logic       VALID_IN,
    output logic [7:0] DATA_OUT,
    output logic       LAST_OUT,
    output logic       VALID_OUT,
    input  logic       READY_IN,
    output logic       ERROR_FRAME,
    output logic [7:0] PKT_COUNT
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t      state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic        stg_vld_q, stg_vld_d;
    logic [7:0]  stg_dat_q, stg_dat_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        wr_en;
    fifo_entry_t wr_dat;
    logic        commit;
    logic        rollback;
    logic        full;
    logic        rd_vld;
    fifo_entry_t rd_dat;

    pcie_rx_commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK0),
        .rst      (RESET),
        .wr_en    (wr_en),
        .wr_dat   (wr_dat),
        .commit   (commit),
        .rollback (rollback),
        .rd_en    (READY_IN),
        .rd_dat   (rd_dat),
        .rd_vld   (rd_vld),
        .full     (full)
    );

    assign VALID_OUT   = rd_vld;
    assign DATA_OUT    = rd_vld ? rd_dat.dat  : 8'h00;
    assign LAST_OUT    = rd_vld ? rd_dat.last : 1'b0;
    assign ERROR_FRAME = err_q;
    assign PKT_COUNT   = cnt_q;

    // The newest payload byte waits in the staging register so END can tag it as last.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        stg_vld_d = stg_vld_q;
        stg_dat_d = stg_dat_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_dat    = '0;
        commit    = 1'b0;
        rollback  = 1'b0;

        if (VALID_IN) begin
            case (state_q)
                ST_IDLE: begin
                    if (K_IN) begin
                        if (DATA_IN == SYM_STP) begin
                            state_d   = ST_PAYLOAD;
                            len_d     = '0;
                            stg_vld_d = 1'b0;
                        end else if (DATA_IN != SYM_COM && DATA_IN != SYM_IDL) begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!K_IN) begin
                        if (len_q == LW'(MAX_LEN) || (stg_vld_q && full)) begin
                            err_d     = 1'b1;
                            rollback  = 1'b1;
                            stg_vld_d = 1'b0;
                            state_d   = ST_DROP;
                        end else begin
                            if (stg_vld_q) begin
                                wr_en  = 1'b1;
                                wr_dat = '{last: 1'b0, dat: stg_dat_q};
                            end
                            stg_vld_d = 1'b1;
                            stg_dat_d = DATA_IN;
                            len_d     = len_q + LW'(1);
                        end
                    end else if (DATA_IN == SYM_END) begin
                        state_d   = ST_IDLE;
                        stg_vld_d = 1'b0;
                        if (!stg_vld_q) begin
                            err_d = 1'b1;
                        end else if (full) begin
                            err_d    = 1'b1;
                            rollback = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            wr_dat = '{last: 1'b1, dat: stg_dat_q};
                            commit = 1'b1;
                            cnt_d  = cnt_q + 8'd1;
                        end
                    end else if (DATA_IN == SYM_EDB) begin
                        rollback  = 1'b1;
                        stg_vld_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else if (DATA_IN == SYM_STP) begin
                        err_d     = 1'b1;
                        rollback  = 1'b1;
                        stg_vld_d = 1'b0;
                        len_d     = '0;
                    end else begin
                        err_d     = 1'b1;
                        rollback  = 1'b1;
                        stg_vld_d = 1'b0;
                        state_d   = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (K_IN) begin
                        if (DATA_IN == SYM_END || DATA_IN == SYM_EDB) begin
                            state_d = ST_IDLE;
                        end else if (DATA_IN == SYM_STP) begin
                            state_d   = ST_PAYLOAD;
                            len_d     = '0;
                            stg_vld_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK0) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            stg_vld_q <= 1'b0;
            stg_dat_q <= 8'h00;
            err_q     <= 1'b0;
            cnt_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            stg_vld_q <= stg_vld_d;
            stg_dat_q <= stg_dat_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pcie_rx_deframer.sv
// Directed bench for pcie_rx_deframer: per-cycle vector table plus multi-cycle sequences.
module tb_pcie_rx_deframer;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       k_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       last_out;
    logic       valid_out;
    logic       ready_in;
    logic       error_frame;
    logic [7:0] pkt_count;

    int checks = 0;
    int errors = 0;

    logic [8:0] outq[$];
    int         err_seen = 0;

    typedef struct {
        logic       vld;
        logic       k;
        logic [7:0] dat;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       ee;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    pcie_rx_deframer #(.DEPTH(16), .MAX_LEN(12)) dut (
        .CLK0        (clk),
        .RESET       (rst),
        .DATA_IN     (data_in),
        .K_IN        (k_in),
        .VALID_IN    (valid_in),
        .DATA_OUT    (data_out),
        .LAST_OUT    (last_out),
        .VALID_OUT   (valid_out),
        .READY_IN    (ready_in),
        .ERROR_FRAME (error_frame),
        .PKT_COUNT   (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out && ready_in) outq.push_back({last_out, data_out});
        if (error_frame) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic vld, input logic k, input logic [7:0] dat);
        valid_in = vld;
        k_in     = k;
        data_in  = dat;
        @(posedge clk);
        #2;
    endtask

    task automatic add(input logic vld, input logic k, input logic [7:0] dat,
                       input logic ev, input logic [7:0] ed, input logic el,
                       input logic ee, input logic [7:0] ec);
        vec_t v;
        v.vld = vld; v.k = k; v.dat = dat;
        v.ev = ev; v.ed = ed; v.el = el; v.ee = ee; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; ready_in = 1'b1;
        valid_in = 1'b0; k_in = 1'b0; data_in = 8'h00;

        // Tests 1-3 as one continuous cycle-by-cycle table.
        add(1,1,8'hFB, 0,8'h00,0,0,8'd0);
        add(1,0,8'h11, 0,8'h00,0,0,8'd0);
        add(1,0,8'h22, 0,8'h00,0,0,8'd0);
        add(1,0,8'h33, 0,8'h00,0,0,8'd0);
        add(1,1,8'hFD, 1,8'h11,0,0,8'd1);
        add(1,1,8'h7C, 1,8'h22,0,0,8'd1);
        add(1,1,8'h7C, 1,8'h33,1,0,8'd1);
        add(1,1,8'hBC, 0,8'h00,0,0,8'd1);
        add(0,1,8'hFB, 0,8'h00,0,0,8'd1);
        add(1,0,8'h99, 0,8'h00,0,0,8'd1);
        add(1,1,8'hFB, 0,8'h00,0,0,8'd1);
        add(1,0,8'hAA, 0,8'h00,0,0,8'd1);
        add(0,0,8'h55, 0,8'h00,0,0,8'd1);
        add(1,0,8'hBB, 0,8'h00,0,0,8'd1);
        add(1,1,8'hFE, 0,8'h00,0,0,8'd1);
        add(1,1,8'hFB, 0,8'h00,0,0,8'd1);
        add(1,0,8'hCC, 0,8'h00,0,0,8'd1);
        add(1,1,8'hFD, 1,8'hCC,1,0,8'd2);
        add(1,1,8'h7C, 0,8'h00,0,0,8'd2);
        add(1,1,8'hFD, 0,8'h00,0,1,8'd2);
        add(1,1,8'hFB, 0,8'h00,0,0,8'd2);
        add(1,1,8'hFD, 0,8'h00,0,1,8'd2);
        add(1,1,8'h7C, 0,8'h00,0,0,8'd2);
        add(1,1,8'hF7, 0,8'h00,0,1,8'd2);
        add(1,1,8'h7C, 0,8'h00,0,0,8'd2);

        step(0,0,8'h00);
        step(0,0,8'h00);
        chk("reset_outputs", {13'd0, valid_out, data_out, last_out, error_frame, pkt_count}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].k, tbl[i].dat);
            chk($sformatf("vec%0d", i),
                {13'd0, valid_out, data_out, last_out, error_frame, pkt_count},
                {13'd0, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].ee, tbl[i].ec});
        end

        // Test 4: 13 payload bytes exceed MAX_LEN.
        outq.delete(); err_seen = 0;
        step(1,1,8'hFB);
        for (int i = 1; i <= 13; i++) begin
            step(1,0,8'(i));
            if (i >= 12) chk($sformatf("maxlen_err_byte%0d", i), {31'd0, error_frame}, (i == 13) ? 32'd1 : 32'd0);
        end
        step(1,1,8'hFD);
        for (int i = 0; i < 3; i++) step(1,1,8'h7C);
        chk("maxlen_err_pulses", err_seen, 1);
        chk("maxlen_no_output", outq.size(), 0);
        chk("maxlen_count", {24'd0, pkt_count}, 2);

        // Test 5: backpressure, fill the FIFO, then overflow with a 4th packet.
        rst = 1'b1; step(0,0,8'h00); rst = 1'b0;
        ready_in = 1'b0; outq.delete(); err_seen = 0;
        for (int p = 0; p < 3; p++) begin
            step(1,1,8'hFB);
            for (int i = 0; i < 5; i++) step(1,0,8'(8'h10 * (p + 1) + i));
            step(1,1,8'hFD);
        end
        chk("fill_count", {24'd0, pkt_count}, 3);
        step(1,1,8'hFB);
        for (int i = 0; i < 5; i++) step(1,0,8'(8'h40 + i));
        step(1,1,8'hFD);
        step(1,1,8'h7C);
        chk("overflow_err_pulses", err_seen, 1);
        chk("overflow_count", {24'd0, pkt_count}, 3);
        chk("stall_head", {23'd0, valid_out, data_out}, {23'd0, 1'b1, 8'h10});
        chk("stall_no_reads", outq.size(), 0);
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) step(1,1,8'h7C);
        chk("drain_size", outq.size(), 15);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) begin
                logic [8:0] expv;
                expv = {(i == 4), 8'(8'h10 * (p + 1) + i)};
                if (outq.size() > 0) chk($sformatf("drain_p%0d_b%0d", p, i), {23'd0, outq.pop_front()}, {23'd0, expv});
                else chk($sformatf("drain_p%0d_b%0d_missing", p, i), 32'd0, {23'd0, expv});
            end
        end

        // Test 6: reset mid-packet with committed data pending.
        ready_in = 1'b0;
        step(1,1,8'hFB); step(1,0,8'h01); step(1,0,8'h02); step(1,1,8'hFD);
        step(1,1,8'hFB); step(1,0,8'h03); step(1,0,8'h04);
        chk("pre_reset_pending", {31'd0, valid_out}, 1);
        rst = 1'b1; step(0,0,8'h00); rst = 1'b0;
        chk("mid_reset_outputs", {22'd0, valid_out, pkt_count, error_frame}, 32'd0);
        err_seen = 0;
        step(1,0,8'h05); step(1,1,8'hFD); step(1,1,8'h7C); step(1,1,8'h7C);
        chk("reset_idle_err", err_seen, 1);
        chk("reset_idle_count", {24'd0, pkt_count}, 0);
        chk("reset_idle_valid", {31'd0, valid_out}, 0);
        ready_in = 1'b1; outq.delete();
        step(1,1,8'hFB); step(1,0,8'h77); step(1,1,8'hFD);
        for (int i = 0; i < 3; i++) step(1,1,8'h7C);
        chk("post_reset_size", outq.size(), 1);
        if (outq.size() > 0) chk("post_reset_byte", {23'd0, outq.pop_front()}, {23'd0, 9'h177});
        chk("post_reset_count", {24'd0, pkt_count}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
